// File: rtl/rvecc_encode_pipe.sv
// Pipelined SECDED (39,32) write-path encoder with a two-entry output buffer
// and a one-shot single/double bit error injector for exercising the decoder.
module rvecc_encode_pipe #(
    parameter int INJ_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [6:0]  out_ecc,
    output logic        out_inj,
    input  logic        inj_arm,
    input  logic [1:0]  inj_mode,
    input  logic [5:0]  inj_pos0,
    input  logic [5:0]  inj_pos1,
    output logic        inj_armed,
    output logic        inj_done,
    output logic [15:0] enc_count
);

    localparam logic [31:0] ECC0_MASK = 32'h56AA_AD5B;
    localparam logic [31:0] ECC1_MASK = 32'h9B33_366D;
    localparam logic [31:0] ECC2_MASK = 32'hE3C3_C78E;
    localparam logic [31:0] ECC3_MASK = 32'h03FC_07F0;
    localparam logic [31:0] ECC4_MASK = 32'h03FF_F800;
    localparam logic [31:0] ECC5_MASK = 32'hFC00_0000;

    function automatic logic [6:0] calc_ecc(input logic [31:0] d);
        logic [5:0] e;
        e[0] = ^(d & ECC0_MASK);
        e[1] = ^(d & ECC1_MASK);
        e[2] = ^(d & ECC2_MASK);
        e[3] = ^(d & ECC3_MASK);
        e[4] = ^(d & ECC4_MASK);
        e[5] = ^(d & ECC5_MASK);
        calc_ecc = {(^d) ^ (^e), e};
    endfunction

    function automatic logic [5:0] sat_pos(input logic [5:0] p);
        sat_pos = (p > 6'd38) ? 6'd38 : p;
    endfunction

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [6:0]  out_ecc_q, out_ecc_d;
    logic        out_inj_q, out_inj_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [6:0]  skid_ecc_q, skid_ecc_d;
    logic        skid_inj_q, skid_inj_d;
    logic        inj_armed_q, inj_armed_d;
    logic [1:0]  inj_mode_q, inj_mode_d;
    logic [5:0]  inj_pos0_q, inj_pos0_d;
    logic [5:0]  inj_pos1_q, inj_pos1_d;
    logic        inj_done_q, inj_done_d;
    logic [15:0] enc_count_q, enc_count_d;

    logic        accept;
    logic        out_free;
    logic        inj_now;
    logic        arm_ok;
    logic [38:0] flip_mask;
    logic [38:0] new_cw;
    logic [5:0]  pos0_sat;
    logic [5:0]  pos1_sat;

    assign in_ready = ~skid_valid_q & ~rst;
    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid_q | out_ready;
    assign inj_now  = accept & inj_armed_q;
    assign arm_ok   = (INJ_EN != 0) && inj_arm && !inj_armed_q &&
                      ((inj_mode == 2'b01) || (inj_mode == 2'b10));
    assign pos0_sat = sat_pos(inj_pos0);
    assign pos1_sat = sat_pos(inj_pos1);

    always_comb begin
        flip_mask = '0;
        if (inj_now) begin
            flip_mask[inj_pos0_q] = 1'b1;
            if (inj_mode_q == 2'b10) begin
                flip_mask[inj_pos1_q] = 1'b1;
            end
        end
    end

    assign new_cw = {calc_ecc(in_data), in_data} ^ flip_mask;

    // Output register and skid behave as a two-entry in-order FIFO
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ecc_d    = out_ecc_q;
        out_inj_d    = out_inj_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ecc_d   = skid_ecc_q;
        skid_inj_d   = skid_inj_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_ecc_d    = skid_ecc_q;
                out_inj_d    = skid_inj_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = new_cw[31:0];
                    skid_ecc_d  = new_cw[38:32];
                    skid_inj_d  = inj_now;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = new_cw[31:0];
                    out_ecc_d  = new_cw[38:32];
                    out_inj_d  = inj_now;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = new_cw[31:0];
            skid_ecc_d   = new_cw[38:32];
            skid_inj_d   = inj_now;
        end
    end

    // inj_done fires only when a corrupted word is loaded into the output register
    always_comb begin
        inj_done_d  = out_free && (skid_valid_q ? skid_inj_q : inj_now);
        inj_armed_d = inj_armed_q;
        inj_mode_d  = inj_mode_q;
        inj_pos0_d  = inj_pos0_q;
        inj_pos1_d  = inj_pos1_q;
        if (inj_now) begin
            inj_armed_d = 1'b0;
        end else if (arm_ok) begin
            inj_armed_d = 1'b1;
            inj_mode_d  = inj_mode;
            inj_pos0_d  = pos0_sat;
            if (pos1_sat == pos0_sat) begin
                inj_pos1_d = (pos0_sat == 6'd38) ? 6'd0 : pos0_sat + 6'd1;
            end else begin
                inj_pos1_d = pos1_sat;
            end
        end
        enc_count_d = (accept && enc_count_q != 16'hFFFF) ? enc_count_q + 16'd1 : enc_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ecc_q    <= '0;
            out_inj_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ecc_q   <= '0;
            skid_inj_q   <= 1'b0;
            inj_armed_q  <= 1'b0;
            inj_mode_q   <= 2'b00;
            inj_pos0_q   <= '0;
            inj_pos1_q   <= '0;
            inj_done_q   <= 1'b0;
            enc_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ecc_q    <= out_ecc_d;
            out_inj_q    <= out_inj_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ecc_q   <= skid_ecc_d;
            skid_inj_q   <= skid_inj_d;
            inj_armed_q  <= inj_armed_d;
            inj_mode_q   <= inj_mode_d;
            inj_pos0_q   <= inj_pos0_d;
            inj_pos1_q   <= inj_pos1_d;
            inj_done_q   <= inj_done_d;
            enc_count_q  <= enc_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ecc   = out_ecc_q;
    assign out_inj   = out_inj_q;
    assign inj_armed = inj_armed_q;
    assign inj_done  = inj_done_q;
    assign enc_count = enc_count_q;

endmodule

// File: tb/tb_rvecc_encode_pipe.sv
// Self-checking bench for rvecc_encode_pipe: directed literal checks plus a
// randomized run compared every cycle against a queue-based codeword model.
module tb_rvecc_encode_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [6:0]  out_ecc;
    logic        out_inj;
    logic        inj_arm;
    logic [1:0]  inj_mode;
    logic [5:0]  inj_pos0;
    logic [5:0]  inj_pos1;
    logic        inj_armed;
    logic        inj_done;
    logic [15:0] enc_count;

    int vectors = 0;
    int miscompares = 0;

    rvecc_encode_pipe #(.INJ_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ecc   (out_ecc),
        .out_inj   (out_inj),
        .inj_arm   (inj_arm),
        .inj_mode  (inj_mode),
        .inj_pos0  (inj_pos0),
        .inj_pos1  (inj_pos1),
        .inj_armed (inj_armed),
        .inj_done  (inj_done),
        .enc_count (enc_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Check-bit membership lists written out exactly as the code definition gives them
    int e0_bits [18] = '{0,1,3,4,6,8,10,11,13,15,17,19,21,23,25,26,28,30};
    int e1_bits [18] = '{0,2,3,5,6,9,10,12,13,16,17,20,21,24,25,27,28,31};
    int e2_bits [18] = '{1,2,3,7,8,9,10,14,15,16,17,22,23,24,25,29,30,31};

    function automatic logic [6:0] model_ecc(input logic [31:0] d);
        logic [6:0] e;
        e = '0;
        for (int i = 0; i < 18; i++) begin
            e[0] ^= d[e0_bits[i]];
            e[1] ^= d[e1_bits[i]];
            e[2] ^= d[e2_bits[i]];
        end
        for (int i = 4; i <= 10; i++) e[3] ^= d[i];
        for (int i = 18; i <= 25; i++) e[3] ^= d[i];
        for (int i = 11; i <= 25; i++) e[4] ^= d[i];
        for (int i = 26; i <= 31; i++) e[5] ^= d[i];
        for (int i = 0; i < 32; i++) e[6] ^= d[i];
        for (int i = 0; i < 6; i++) e[6] ^= e[i];
        return e;
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [6:0]  ecc;
        logic        inj;
    } word_t;

    word_t q[$];
    int    m_age = 0;
    bit    m_armed = 0;
    int    m_mode = 0;
    int    m_p0 = 0;
    int    m_p1 = 0;
    int    m_count = 0;
    bit    started = 0;
    bit    last_rst = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare and update, once per cycle on the falling edge
    always @(negedge clk) begin
        bit    acc;
        bit    drn;
        bit    was_nonempty;
        word_t w;
        logic [38:0] cw;
        if (started) begin
            checkOutput("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                checkOutput("out_data", out_data, q[0].data);
                checkOutput("out_ecc", out_ecc, q[0].ecc);
                checkOutput("out_inj", out_inj, q[0].inj);
            end
            if (last_rst) begin
                checkOutput("rst_out_data", out_data, 0);
                checkOutput("rst_out_ecc", out_ecc, 0);
                checkOutput("rst_out_inj", out_inj, 0);
            end
            checkOutput("in_ready", in_ready, (!rst && q.size() < 2));
            checkOutput("inj_done", inj_done, (q.size() != 0 && q[0].inj && m_age == 0));
            checkOutput("inj_armed", inj_armed, m_armed);
            checkOutput("enc_count", enc_count, m_count);
        end
        if (rst) begin
            q.delete();
            m_armed  = 0;
            m_count  = 0;
            m_age    = 0;
            started  = 1;
            last_rst = 1;
        end else if (started) begin
            last_rst     = 0;
            acc          = in_valid && (q.size() < 2);
            drn          = (q.size() != 0) && out_ready;
            was_nonempty = (q.size() != 0);
            if (drn) begin
                void'(q.pop_front());
                m_age = 0;
            end else if (was_nonempty) begin
                m_age++;
            end
            if (acc) begin
                cw = {model_ecc(in_data), in_data};
                w.inj = 1'b0;
                if (m_armed) begin
                    cw[m_p0] = ~cw[m_p0];
                    if (m_mode == 2) cw[m_p1] = ~cw[m_p1];
                    w.inj = 1'b1;
                end
                w.data = cw[31:0];
                w.ecc  = cw[38:32];
                q.push_back(w);
                if (m_count < 65535) m_count++;
            end
            if (acc && m_armed) begin
                m_armed = 0;
            end else if (!m_armed && inj_arm && (inj_mode == 2'b01 || inj_mode == 2'b10)) begin
                m_armed = 1;
                m_mode  = inj_mode;
                m_p0    = (inj_pos0 > 38) ? 38 : inj_pos0;
                m_p1    = (inj_pos1 > 38) ? 38 : inj_pos1;
                if (m_p1 == m_p0) m_p1 = (m_p0 + 1) % 39;
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and wait (bounded) until it is accepted
    task automatic applyStimulus(input logic [31:0] d);
        int n;
        bit acc;
        n   = 0;
        acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n < 20) begin
            acc = in_ready;
            stepCycle();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: word %0h not accepted within 20 cycles", d);
        end
    endtask

    task automatic armInjection(input logic [1:0] mode, input logic [5:0] p0, input logic [5:0] p1);
        inj_arm  = 1'b1;
        inj_mode = mode;
        inj_pos0 = p0;
        inj_pos1 = p1;
        stepCycle();
        inj_arm  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        inj_arm   = 1'b0;
        inj_mode  = 2'b00;
        inj_pos0  = '0;
        inj_pos1  = '0;
        repeat (3) stepCycle();
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_enc_count", enc_count, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", in_ready, 1);
        stepCycle();

        $display("[TB] encode values");
        applyStimulus(32'h0000_0000);
        checkOutput("enc0_valid", out_valid, 1);
        checkOutput("enc0_ecc", out_ecc, 7'h00);
        applyStimulus(32'h0000_0001);
        checkOutput("enc1_ecc", out_ecc, 7'h43);
        applyStimulus(32'hFFFF_FFFF);
        checkOutput("encF_ecc", out_ecc, 7'h18);
        checkOutput("enc_count3", enc_count, 3);
        stepCycle();

        $display("[TB] single injection");
        armInjection(2'b01, 6'd0, 6'd0);
        checkOutput("single_armed", inj_armed, 1);
        applyStimulus(32'h0000_0001);
        checkOutput("single_data", out_data, 32'h0);
        checkOutput("single_ecc", out_ecc, 7'h43);
        checkOutput("single_inj", out_inj, 1);
        checkOutput("single_done", inj_done, 1);
        checkOutput("single_disarm", inj_armed, 0);
        stepCycle();
        checkOutput("single_done_once", inj_done, 0);
        applyStimulus(32'h0000_0002);
        checkOutput("clean_after_inj", out_inj, 0);
        stepCycle();

        $display("[TB] double injection");
        armInjection(2'b10, 6'd32, 6'd38);
        applyStimulus(32'h0000_0000);
        checkOutput("double_data", out_data, 32'h0);
        checkOutput("double_ecc", out_ecc, 7'h41);
        armInjection(2'b10, 6'd5, 6'd5);
        applyStimulus(32'h0000_0000);
        checkOutput("double_same_data", out_data, 32'h60);
        checkOutput("double_same_ecc", out_ecc, 7'h00);
        stepCycle();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(32'hA);
        in_valid = 1'b1;
        in_data  = 32'hB;
        stepCycle();
        in_data  = 32'hC;
        checkOutput("bp_in_ready_low", in_ready, 0);
        repeat (2) stepCycle();
        checkOutput("bp_hold_data", out_data, 32'hA);
        checkOutput("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        applyStimulus(32'hC);
        checkOutput("bp_last_data", out_data, 32'hC);
        repeat (2) stepCycle();

        $display("[TB] arm and accept in the same cycle");
        inj_arm  = 1'b1;
        inj_mode = 2'b01;
        inj_pos0 = 6'd3;
        in_valid = 1'b1;
        in_data  = 32'h1;
        stepCycle();
        inj_arm  = 1'b0;
        in_valid = 1'b0;
        checkOutput("same_cycle_clean_data", out_data, 32'h1);
        checkOutput("same_cycle_clean_inj", out_inj, 0);
        checkOutput("same_cycle_armed", inj_armed, 1);
        armInjection(2'b10, 6'd0, 6'd1);
        applyStimulus(32'h10);
        checkOutput("rearm_ignored_data", out_data, 32'h18);
        checkOutput("rearm_ignored_ecc", out_ecc, 7'h49);
        checkOutput("rearm_ignored_inj", out_inj, 1);
        stepCycle();

        $display("[TB] reset mid-stall");
        out_ready = 1'b0;
        applyStimulus(32'h100);
        applyStimulus(32'h200);
        armInjection(2'b01, 6'd7, 6'd0);
        checkOutput("stall_armed", inj_armed, 1);
        rst = 1'b1;
        stepCycle();
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_data", out_data, 0);
        checkOutput("midrst_armed", inj_armed, 0);
        checkOutput("midrst_count", enc_count, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) stepCycle();
        checkOutput("no_stale_word", out_valid, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 399) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            inj_arm   = ($urandom_range(0, 15) == 0);
            inj_mode  = 2'($urandom_range(0, 3));
            inj_pos0  = 6'($urandom_range(0, 63));
            inj_pos1  = ($urandom_range(0, 3) == 0) ? inj_pos0 : 6'($urandom_range(0, 63));
            stepCycle();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        inj_arm   = 1'b0;
        out_ready = 1'b1;
        repeat (4) stepCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rvecc_encode_pipe.md
# rvecc_encode_pipe

Pipelined SECDED (39,32) ECC encoder for the write path into ECC-protected SRAMs (DCCM/ICCM data arrays). It accepts 32-bit write data over a valid/ready handshake, produces the 7-bit check field consumed by the existing ECC decoder on the read path, and buffers one extra word for full throughput under backpressure. It also provides a one-shot error-injection controller so benches and firmware can plant single- or double-bit errors and exercise the decoder.

## Interface
- INJ_EN, default 1: 1 = injection logic present; 0 = injection inputs ignored, `out_inj`/`inj_armed`/`inj_done` tied 0.
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  write word offered.
- in_ready  out  1  block can accept; transfer when `in_valid & in_ready`.
- in_data  in  32  write data.
- out_valid  out  1  encoded word available.
- out_ready  in  1  downstream accepts; transfer when `out_valid & out_ready`.
- out_data  out  32  data field of codeword (post-injection).
- out_ecc  out  7  check field (post-injection).
- out_inj  out  1  this output word was deliberately corrupted.
- inj_arm  in  1  one-cycle pulse: latch injection request.
- inj_mode  in  2  00 none, 01 single flip, 10 double flip, 11 reserved (treated as 00).
- inj_pos0  in  6  first flip position, codeword index 0..38.
- inj_pos1  in  6  second flip position (double mode only).
- inj_armed  out  1  request latched, waiting for a word.
- inj_done  out  1  one-cycle pulse when a corrupted word first presents at output.
- enc_count  out  16  words accepted since reset, saturating at 0xFFFF.

## Operation
- Check bits computed from pre-injection data, XOR of listed data bits:
  - ecc[0]: 0,1,3,4,6,8,10,11,13,15,17,19,21,23,25,26,28,30
  - ecc[1]: 0,2,3,5,6,9,10,12,13,16,17,20,21,24,25,27,28,31
  - ecc[2]: 1,2,3,7,8,9,10,14,15,16,17,22,23,24,25,29,30,31
  - ecc[3]: 4–10, 18–25
  - ecc[4]: 11–25
  - ecc[5]: 26–31
  - ecc[6]: XOR of all 32 data bits and ecc[5:0] (overall even parity of the 39-bit word).
- Codeword index: 0..31 = data[i], 32..38 = ecc[i-32]. Positions >38 saturate to 38.
- Injection: `inj_arm` while `inj_armed`=0 and mode≠00/11 latches mode/positions and sets `inj_armed`. `inj_arm` while armed is ignored. The next accepted word (acceptance strictly after the arm cycle) is corrupted: single flips pos0; double flips pos0 and pos1, and if pos1==pos0 the second flip uses (pos0+1) mod 39. `inj_armed` clears on that acceptance; the word carries `out_inj`=1.
- Buffering: output register plus one skid register, two-entry FIFO semantics, strict in-order delivery.
- `enc_count` increments on each input acceptance and holds at 0xFFFF.

## Timing
- Reset (rst high at an edge): out_valid=0, out_data=0, out_ecc=0, out_inj=0, inj_armed=0, inj_done=0, enc_count=0, skid empty. in_ready=0 while rst high, 1 the first cycle after.
- Latency: word accepted at edge N appears on outputs after edge N (out_valid high cycle N+1) if the output register is empty or draining that cycle.
- in_ready = skid empty (registered, no combinational path from out_ready).
- Output stalled (out_valid & ~out_ready): the next accepted word goes to the skid register; in_ready drops the following cycle. With out_ready held high, one word per cycle sustained.
- Simultaneous output drain and input accept with skid full: skid moves to output, new word to skid, no loss.
- out_* stable while out_valid & ~out_ready.
- inj_done pulses the first cycle a word with out_inj=1 is at the output (once per injection, even if stalled).
- rst mid-transfer discards buffered words and any armed injection.

## Test plan
- Encode values, out_ready=1: in_data 0x00000000 -> out_ecc 0x00; 0x00000001 -> out_ecc 0x43; 0xFFFFFFFF -> out_ecc 0x18; out_valid one cycle after acceptance.
- Single injection: arm mode 01, pos0=0; send 0x00000001 -> out_data 0x00000000, out_ecc 0x43, out_inj=1, inj_done one pulse, inj_armed 0; the next word is clean.
- Double injection: arm mode 10, pos0=32, pos1=38; send 0x00000000 -> out_ecc 0x41, out_data 0; pos0=pos1=5 on 0 -> out_data 0x00000060.
- Backpressure: out_ready=0, offer 0xA, 0xB, 0xC back-to-back -> 0xA and 0xB accepted, in_ready low; release -> outputs 0xA, 0xB, 0xC in order, no duplicates.
- Arm/accept same cycle: inj_arm coincides with acceptance of 0x1 -> 0x1 clean; the following word is corrupted. A second inj_arm while armed is ignored.
- Reset mid-stall with skid full and armed -> all outputs at reset values, enc_count 0, no stale word emitted afterward.
